// File: rtl/ofm_pkg.sv
// Shared sizing constants and FSM state type for the OFM write-back path.
package ofm_pkg;
   localparam int NUM_PE = 16;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 13;
   localparam int DIM_W  = 9;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;
endpackage

// File: rtl/ofm_writeback_if.sv
// PE result capture and OFM buffer write bus; master is the write-back engine.
interface ofm_writeback_if #(
   parameter int NUM_PE = ofm_pkg::NUM_PE,
   parameter int DATA_W = ofm_pkg::DATA_W,
   parameter int ADDR_W = ofm_pkg::ADDR_W
);
   logic [NUM_PE-1:0]        pe_valid;
   logic [NUM_PE*DATA_W-1:0] pe_data;
   logic                     pe_ready;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     wr_ready;

   modport master (
      input  pe_valid, pe_data, wr_ready,
      output pe_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output pe_valid, pe_data, wr_ready,
      input  pe_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/lane_select.sv
// Lowest-set-bit priority encoder over the pending-lane mask.
module lane_select #(
   parameter int N     = ofm_pkg::NUM_PE,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             any_set
);
   always_comb begin
      idx     = '0;
      any_set = 1'b0;
      // Scanning downward lets the lowest set bit be the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx     = IDX_W'(i);
            any_set = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ofm_writeback.sv
// Captures one bank of PE results and drains the valid lanes, one per cycle,
// into the OFM buffer at the linear (channel, row, col) address.
module ofm_writeback #(
   parameter int NUM_PE = ofm_pkg::NUM_PE,
   parameter int DATA_W = ofm_pkg::DATA_W,
   parameter int ADDR_W = ofm_pkg::ADDR_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [8:0] ofm_width,
   input  logic [8:0] ofm_height,
   input  logic [8:0] num_channel,
   ofm_writeback_if.master bus,
   output logic       row_done,
   output logic       channel_done,
   output logic       done,
   output logic       busy,
   output logic       cfg_err,
   output logic       ovf_err
);
   import ofm_pkg::*;

   localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   state_t              state_reg, state_next;
   logic [NUM_PE-1:0]   pend_reg, pend_next;
   logic [DATA_W-1:0]   bank_reg [NUM_PE];
   logic [DATA_W-1:0]   lane_data [NUM_PE];
   logic [8:0]          col_reg, col_next, row_reg, row_next, ch_reg, ch_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic                row_done_reg, row_done_next, ch_done_reg, ch_done_next;
   logic                cfg_err_reg, cfg_err_next, ovf_err_reg, ovf_err_next;
   logic                live_reg;
   logic [IDX_W-1:0]    sel_idx;
   logic                sel_any, cfg_zero, capture, xfer;

   generate
      for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
         assign lane_data[gi] = bus.pe_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   lane_select #(.N(NUM_PE), .IDX_W(IDX_W)) u_lane_select (
      .req     (pend_reg),
      .idx     (sel_idx),
      .any_set (sel_any)
   );

   assign cfg_zero     = (ofm_width == 9'd0) || (ofm_height == 9'd0) || (num_channel == 9'd0);
   // live_reg keeps pe_ready low through the cycle in which reset is released.
   assign bus.pe_ready = (state_reg == ST_IDLE) && en && live_reg && !cfg_err_reg && !cfg_zero;
   assign capture      = bus.pe_ready && (|bus.pe_valid);
   assign bus.wr_en    = (state_reg == ST_DRAIN) && sel_any;
   assign bus.wr_addr  = addr_reg;
   assign bus.wr_data  = bank_reg[sel_idx];
   assign xfer         = bus.wr_en && bus.wr_ready;

   assign row_done     = row_done_reg;
   assign channel_done = ch_done_reg;
   assign done         = (state_reg == ST_FINISH);
   assign busy         = (state_reg != ST_IDLE);
   assign cfg_err      = cfg_err_reg;
   assign ovf_err      = ovf_err_reg;

   always_comb begin
      state_next    = state_reg;
      pend_next     = pend_reg;
      col_next      = col_reg;
      row_next      = row_reg;
      ch_next       = ch_reg;
      addr_next     = addr_reg;
      row_done_next = 1'b0;
      ch_done_next  = 1'b0;
      cfg_err_next  = cfg_err_reg;
      ovf_err_next  = ovf_err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (cfg_zero) cfg_err_next = 1'b1;
            if (capture) begin
               pend_next  = bus.pe_valid;
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!sel_any) begin
               state_next = ST_IDLE;
            end else if (xfer) begin
               pend_next[sel_idx] = 1'b0;
               addr_next          = addr_reg + ADDR_W'(1);
               if (col_reg != ofm_width - 9'd1) begin
                  col_next = col_reg + 9'd1;
               end else begin
                  col_next      = 9'd0;
                  row_done_next = 1'b1;
                  if (row_reg != ofm_height - 9'd1) begin
                     row_next = row_reg + 9'd1;
                  end else begin
                     row_next     = 9'd0;
                     ch_done_next = 1'b1;
                     if (ch_reg != num_channel - 9'd1) begin
                        ch_next = ch_reg + 9'd1;
                     end else begin
                        // OFM complete: anything still pending has nowhere to go.
                        ch_next    = 9'd0;
                        state_next = ST_FINISH;
                        if (pend_next != '0) ovf_err_next = 1'b1;
                        pend_next  = '0;
                     end
                  end
               end
               if (state_next == ST_DRAIN && pend_next == '0) state_next = ST_IDLE;
            end
         end
         ST_FINISH: begin
            col_next   = 9'd0;
            row_next   = 9'd0;
            ch_next    = 9'd0;
            addr_next  = '0;
            pend_next  = '0;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         pend_reg     <= '0;
         col_reg      <= '0;
         row_reg      <= '0;
         ch_reg       <= '0;
         addr_reg     <= '0;
         row_done_reg <= 1'b0;
         ch_done_reg  <= 1'b0;
         cfg_err_reg  <= 1'b0;
         ovf_err_reg  <= 1'b0;
         live_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pend_reg     <= pend_next;
         col_reg      <= col_next;
         row_reg      <= row_next;
         ch_reg       <= ch_next;
         addr_reg     <= addr_next;
         row_done_reg <= row_done_next;
         ch_done_reg  <= ch_done_next;
         cfg_err_reg  <= cfg_err_next;
         ovf_err_reg  <= ovf_err_next;
         live_reg     <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PE; i++) begin
         if (reset)        bank_reg[i] <= '0;
         else if (capture) bank_reg[i] <= lane_data[i];
      end
   end
endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback with a write scoreboard filled at capture time.
module tb_ofm_writeback;
   localparam int NUM_PE = 16;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 13;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      bit                rw;
      bit                cw;
      bit                dn;
   } exp_t;

   logic       clk, reset, en;
   logic [8:0] ofm_width, ofm_height, num_channel;
   logic       row_done, channel_done, done, busy, cfg_err, ovf_err;

   ofm_writeback_if #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ofm_writeback #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .ofm_width    (ofm_width),
      .ofm_height   (ofm_height),
      .num_channel  (num_channel),
      .bus          (bus),
      .row_done     (row_done),
      .channel_done (channel_done),
      .done         (done),
      .busy         (busy),
      .cfg_err      (cfg_err),
      .ovf_err      (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   cap_cyc = 0;
   exp_t sb[$];
   int   xcyc[$];
   bit   prev_rw, prev_cw, prev_dn;
   int   m_col, m_row, m_ch;
   int   g_w, g_h, g_c;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observe one cycle at the falling edge, then step just past the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      check("row_done", row_done, prev_rw);
      check("channel_done", channel_done, prev_cw);
      check("done", done, prev_dn);
      prev_rw = 0; prev_cw = 0; prev_dn = 0;
      if (!reset && bus.wr_en && bus.wr_ready) begin
         xcyc.push_back(cyc);
         check("sb_nonempty", sb.size() > 0, 1'b1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_addr", bus.wr_addr, e.addr);
            check("wr_data", bus.wr_data, e.data);
            prev_rw = e.rw; prev_cw = e.cw; prev_dn = e.dn;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_geom(input int w, input int h, input int c);
      g_w = w; g_h = h; g_c = c;
      ofm_width = 9'(w); ofm_height = 9'(h); num_channel = 9'(c);
   endtask

   task automatic model_reset();
      m_col = 0; m_row = 0; m_ch = 0;
      sb.delete();
   endtask

   task automatic push_set(input logic [15:0] v, input logic [127:0] d);
      exp_t e;
      bit   fin;
      fin = 0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (v[i] && !fin) begin
            e.addr = ADDR_W'(m_ch * g_w * g_h + m_row * g_w + m_col);
            e.data = d[i*8 +: 8];
            e.rw = 0; e.cw = 0; e.dn = 0;
            m_col++;
            if (m_col == g_w) begin
               m_col = 0; e.rw = 1; m_row++;
               if (m_row == g_h) begin
                  m_row = 0; e.cw = 1; m_ch++;
                  if (m_ch == g_c) begin
                     m_ch = 0; e.dn = 1; fin = 1;
                  end
               end
            end
            sb.push_back(e);
         end
      end
   endtask

   task automatic load(input logic [15:0] v, input logic [127:0] d);
      bit got;
      got = 0;
      bus.pe_valid = v;
      bus.pe_data  = d;
      for (int i = 0; i < 50 && !got; i++) begin
         if (bus.pe_ready) begin
            push_set(v, d);
            got = 1;
            cap_cyc = cyc + 1;
         end
         tick();
      end
      check("capture_taken", got, 1'b1);
      bus.pe_valid = '0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (!busy && sb.size() == 0) ok = 1;
         else tick();
      end
      check("drain_timeout", ok, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      prev_rw = 0; prev_cw = 0; prev_dn = 0;
   endtask

   initial begin
      logic [127:0] d;
      logic [ADDR_W-1:0] hold_addr;
      logic [DATA_W-1:0] hold_data;

      reset = 1'b1; en = 1'b1;
      bus.wr_ready = 1'b0; bus.pe_valid = '0; bus.pe_data = '0;
      set_geom(4, 2, 1);
      model_reset();
      prev_rw = 0; prev_cw = 0; prev_dn = 0;
      tick(); tick();
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_pe_ready", bus.pe_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_addr", bus.wr_addr, 13'd0);
      check("rst_wr_data", bus.wr_data, 8'd0);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_ovf_err", ovf_err, 1'b0);
      reset = 1'b0;
      tick(); tick();
      check("ready_after_rst", bus.pe_ready, 1'b1);

      // 4x2x1, lanes 0..7 carrying 1..8
      bus.wr_ready = 1'b1;
      d = '0;
      for (int i = 0; i < NUM_PE; i++) d[i*8 +: 8] = 8'(i + 1);
      xcyc.delete();
      load(16'h00FF, d);
      wait_idle();
      tick();
      check("t1_writes", xcyc.size(), 8);
      check("t1_ovf", ovf_err, 1'b0);
      check("t1_addr_cleared", bus.wr_addr, 13'd0);

      // sparse lanes 0 and 15 drain back to back
      set_geom(8, 8, 4);
      d = '0; d[7:0] = 8'hA5; d[127:120] = 8'h3C;
      xcyc.delete();
      load(16'h8001, d);
      wait_idle();
      tick();
      check("t2_writes", xcyc.size(), 2);
      if (xcyc.size() == 2) check("t2_consecutive", xcyc[1] - xcyc[0], 1);

      // full bank, no stall: 16 consecutive cycles starting right after capture
      for (int i = 0; i < NUM_PE; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
      xcyc.delete();
      load(16'hFFFF, d);
      wait_idle();
      tick();
      check("t4_writes", xcyc.size(), 16);
      if (xcyc.size() == 16) begin
         check("t4_first_latency", xcyc[0], cap_cyc + 1);
         check("t4_span", xcyc[15] - xcyc[0], 15);
      end

      // stall mid-drain with en dropped: drain must still finish
      for (int i = 0; i < NUM_PE; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
      load(16'hFFFF, d);
      tick(); tick();
      en = 1'b0;
      bus.wr_ready = 1'b0;
      hold_addr = bus.wr_addr;
      hold_data = bus.wr_data;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_wr_en", bus.wr_en, 1'b1);
         check("stall_addr", bus.wr_addr, hold_addr);
         check("stall_data", bus.wr_data, hold_data);
      end
      bus.wr_ready = 1'b1;
      wait_idle();
      tick();
      check("en0_pe_ready", bus.pe_ready, 1'b0);
      check("t3_sb_empty", sb.size(), 0);
      en = 1'b1;
      tick();

      // OFM completes with lanes left over
      do_reset();
      tick();
      check("rst_clears_ovf", ovf_err, 1'b0);
      set_geom(2, 1, 1);
      for (int i = 0; i < NUM_PE; i++) d[i*8 +: 8] = 8'(16 + i);
      xcyc.delete();
      load(16'h000F, d);
      wait_idle();
      tick();
      check("t5_writes", xcyc.size(), 2);
      check("t5_ovf", ovf_err, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_bank_empty", bus.wr_en, 1'b0);
         check("t5_idle", busy, 1'b0);
      end

      // reset arriving on the 3rd write of a full drain
      do_reset();
      set_geom(8, 8, 4);
      tick();
      load(16'hFFFF, d);
      tick(); tick();
      check("t6_third_write", bus.wr_en, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      prev_rw = 0; prev_cw = 0; prev_dn = 0;
      check("t6_wr_en_off", bus.wr_en, 1'b0);
      check("t6_addr_zero", bus.wr_addr, 13'd0);
      check("t6_busy", busy, 1'b0);
      tick(); tick();
      check("t6_pe_ready", bus.pe_ready, 1'b1);
      tick();

      // zero height: configuration error locks out capture until reset
      ofm_height = 9'd0;
      tick();
      check("t7_cfg_err", cfg_err, 1'b1);
      check("t7_pe_ready", bus.pe_ready, 1'b0);
      bus.pe_valid = 16'h0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t7_no_capture", busy, 1'b0);
      end
      bus.pe_valid = '0;
      ofm_height = 9'd8;
      tick();
      check("t7_sticky_cfg", cfg_err, 1'b1);
      check("t7_still_blocked", bus.pe_ready, 1'b0);
      do_reset();
      tick(); tick();
      check("t7_cfg_cleared", cfg_err, 1'b0);
      check("t7_ready_again", bus.pe_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
